// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator.
// Carries counters, pixel coordinates, syncs and strobes to consumers.
interface vga_timing_gen_if #(
   parameter int CW = 11
);
   logic [CW-1:0] pos_H;
   logic [CW-1:0] pos_V;
   logic [CW-1:0] pix_X;
   logic [CW-1:0] pix_Y;
   logic          HSync;
   logic          VSync;
   logic          vga_Ready;
   logic          line_Start;
   logic          frame_Start;
   logic          v_Blank;
   logic [15:0]   frame_Cnt;

   modport master (
      output pos_H,
      output pos_V,
      output pix_X,
      output pix_Y,
      output HSync,
      output VSync,
      output vga_Ready,
      output line_Start,
      output frame_Start,
      output v_Blank,
      output frame_Cnt
   );

   modport slave (
      input pos_H,
      input pos_V,
      input pix_X,
      input pix_Y,
      input HSync,
      input VSync,
      input vga_Ready,
      input line_Start,
      input frame_Start,
      input v_Blank,
      input frame_Cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Syncs and enable are delayed PIPE enabled clocks to match pixel fetch.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CW       = 11,
   parameter int PIPE     = 2
) (
   input  logic             vga_CLK,
   input  logic             vga_RST,
   input  logic             vga_CE,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SS    = H_ACTIVE + H_FRONT;
   localparam int H_SE    = H_SS + H_SYNC;
   localparam int V_SS    = V_ACTIVE + V_FRONT;
   localparam int V_SE    = V_SS + V_SYNC;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic          HP     = 1'(H_POL);
   localparam logic          VP     = 1'(V_POL);

   logic [CW-1:0] pos_h;
   logic [CW-1:0] pos_v;
   logic [15:0]   frame_cnt;
   logic [31:0]   h32;
   logic [31:0]   v32;
   logic          h_end;
   logic          v_end;
   logic          hs0;
   logic          vs0;
   logic          de0;
   logic          hs_lvl;
   logic          vs_lvl;
   logic          line_st;

   assign h_end = (pos_h == H_LAST);
   assign v_end = (pos_v == V_LAST);

   always_ff @(posedge vga_CLK) begin
      if (vga_RST) begin
         pos_h     <= '0;
         pos_v     <= '0;
         frame_cnt <= '0;
      end else if (vga_CE) begin
         if (h_end) begin
            pos_h <= '0;
            if (v_end) begin
               pos_v     <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               pos_v <= pos_v + CW'(1);
            end
         end else begin
            pos_h <= pos_h + CW'(1);
         end
      end
   end

   // Compare in 32 bits so a sync region ending at 2^CW cannot alias.
   assign h32 = 32'(pos_h);
   assign v32 = 32'(pos_v);

   assign hs0 = (h32 >= H_SS) && (h32 < H_SE);
   assign vs0 = (v32 >= V_SS) && (v32 < V_SE);
   assign de0 = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);

   assign hs_lvl = hs0 ? HP : ~HP;
   assign vs_lvl = vs0 ? VP : ~VP;

   generate
      if (PIPE == 0) begin : g_nopipe
         assign vga.HSync     = hs_lvl;
         assign vga.VSync     = vs_lvl;
         assign vga.vga_Ready = de0;
      end else begin : g_pipe
         logic [PIPE-1:0] hs_q;
         logic [PIPE-1:0] vs_q;
         logic [PIPE-1:0] de_q;

         always_ff @(posedge vga_CLK) begin
            if (vga_RST) begin
               hs_q <= {PIPE{~HP}};
               vs_q <= {PIPE{~VP}};
               de_q <= '0;
            end else if (vga_CE) begin
               hs_q[0] <= hs_lvl;
               vs_q[0] <= vs_lvl;
               de_q[0] <= de0;
               for (int i = 1; i < PIPE; i++) begin
                  hs_q[i] <= hs_q[i-1];
                  vs_q[i] <= vs_q[i-1];
                  de_q[i] <= de_q[i-1];
               end
            end
         end

         assign vga.HSync     = hs_q[PIPE-1];
         assign vga.VSync     = vs_q[PIPE-1];
         assign vga.vga_Ready = de_q[PIPE-1];
      end
   endgenerate

   // Strobes are gated by the enable so a stall cannot repeat them.
   assign line_st = vga_CE && (pos_h == '0);

   assign vga.pos_H       = pos_h;
   assign vga.pos_V       = pos_v;
   assign vga.pix_X       = de0 ? pos_h : '0;
   assign vga.pix_Y       = de0 ? pos_v : '0;
   assign vga.line_Start  = line_st;
   assign vga.frame_Start = line_st && (pos_v == '0);
   assign vga.v_Blank     = (v32 >= V_ACTIVE);
   assign vga.frame_Cnt   = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// Four configurations: defaults, inverted polarity, small, tall.
module tb_vga_timing_gen;

   logic clk;
   logic rst_a, ce_a;
   logic rst_b, ce_b;
   logic rst_c, ce_c;
   logic rst_d, ce_d;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(11)) if_a ();
   vga_timing_gen_if #(.CW(11)) if_b ();
   vga_timing_gen_if #(.CW(4))  if_c ();
   vga_timing_gen_if #(.CW(11)) if_d ();

   vga_timing_gen #(
      .PIPE(2)
   ) dut_a (
      .vga_CLK(clk), .vga_RST(rst_a), .vga_CE(ce_a), .vga(if_a)
   );

   vga_timing_gen #(
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_POL(1), .V_POL(1), .PIPE(0)
   ) dut_b (
      .vga_CLK(clk), .vga_RST(rst_b), .vga_CE(ce_b), .vga(if_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .CW(4), .PIPE(2)
   ) dut_c (
      .vga_CLK(clk), .vga_RST(rst_c), .vga_CE(ce_c), .vga(if_c)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .PIPE(0)
   ) dut_d (
      .vga_CLK(clk), .vga_RST(rst_d), .vga_CE(ce_d), .vga(if_d)
   );

   task automatic test_reset();
      rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
      ce_a = 1; ce_b = 1; ce_c = 1; ce_d = 1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (if_a.pos_H !== 11'd0 || if_a.pos_V !== 11'd0) begin
         errors++;
         $display("FAIL rst_pos got %0d,%0d want 0,0",
                  if_a.pos_H, if_a.pos_V);
      end
      checks++;
      if (if_a.HSync !== 1'b1 || if_a.VSync !== 1'b1) begin
         errors++;
         $display("FAIL rst_sync_a got %b%b want 11",
                  if_a.HSync, if_a.VSync);
      end
      checks++;
      if (if_a.vga_Ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ready got %b want 0", if_a.vga_Ready);
      end
      checks++;
      if (if_a.frame_Cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_fcnt got %0d want 0", if_a.frame_Cnt);
      end
      checks++;
      if (if_b.HSync !== 1'b0 || if_b.VSync !== 1'b0) begin
         errors++;
         $display("FAIL rst_sync_b got %b%b want 00",
                  if_b.HSync, if_b.VSync);
      end
      rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
      ce_b = 0; ce_c = 0; ce_d = 0;
      #1;
      checks++;
      if (if_a.frame_Start !== 1'b1 || if_a.line_Start !== 1'b1) begin
         errors++;
         $display("FAIL rst_strobe got %b%b want 11",
                  if_a.frame_Start, if_a.line_Start);
      end
      ce_a = 0;
   endtask

   task automatic test_line_a();
      int bad = 0, hs_low = 0, first_low = -1;
      int first_rdy = -1, rdy = 0, lines = 0, frames = 0;
      rst_a = 1; ce_a = 1;
      @(negedge clk);
      rst_a = 0;
      for (int k = 0; k < 1600; k++) begin
         int h, v, px;
         #1;
         h = k % 800;
         v = k / 800;
         px = (h < 640) ? h : 0;
         if (if_a.pos_H !== 11'(h) || if_a.pos_V !== 11'(v) ||
             if_a.pix_X !== 11'(px)) begin
            if (bad == 0)
               $display("FAIL a_pos k=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                        k, if_a.pos_H, if_a.pos_V, if_a.pix_X, h, v, px);
            bad++;
         end
         if (if_a.HSync == 1'b0) begin
            hs_low++;
            if (first_low < 0) first_low = k;
         end
         if (if_a.vga_Ready == 1'b1) begin
            rdy++;
            if (first_rdy < 0) first_rdy = k;
         end
         lines += int'(if_a.line_Start);
         frames += int'(if_a.frame_Start);
         @(negedge clk);
      end
      ce_a = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL a_counters got %0d bad want 0", bad);
      end
      checks++;
      if (hs_low != 192) begin
         errors++;
         $display("FAIL a_hs_width got %0d want 192", hs_low);
      end
      checks++;
      if (first_low != 658) begin
         errors++;
         $display("FAIL a_hs_fall got %0d want 658", first_low);
      end
      checks++;
      if (first_rdy != 2) begin
         errors++;
         $display("FAIL a_rdy_rise got %0d want 2", first_rdy);
      end
      checks++;
      if (rdy != 1280) begin
         errors++;
         $display("FAIL a_rdy_count got %0d want 1280", rdy);
      end
      checks++;
      if (lines != 2 || frames != 1) begin
         errors++;
         $display("FAIL a_strobes got %0d,%0d want 2,1", lines, frames);
      end
   endtask

   task automatic test_ce_toggle_a();
      int bad = 0, lines = 0, first_rdy = -1;
      rst_a = 1; ce_a = 1;
      @(negedge clk);
      rst_a = 0;
      for (int j = 0; j < 1700; j++) begin
         int h;
         logic ls;
         ce_a = (j % 2 == 0);
         #1;
         h = ((j + 1) / 2) % 800;
         ls = ce_a && (h == 0);
         if (if_a.pos_H !== 11'(h) || if_a.line_Start !== ls) begin
            if (bad == 0)
               $display("FAIL ce_step j=%0d got %0d,%b want %0d,%b",
                        j, if_a.pos_H, if_a.line_Start, h, ls);
            bad++;
         end
         lines += int'(if_a.line_Start);
         if (if_a.vga_Ready == 1'b1 && first_rdy < 0) first_rdy = j;
         @(negedge clk);
      end
      ce_a = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ce_counters got %0d bad want 0", bad);
      end
      checks++;
      if (lines != 2) begin
         errors++;
         $display("FAIL ce_lines got %0d want 2", lines);
      end
      checks++;
      if (first_rdy != 3) begin
         errors++;
         $display("FAIL ce_pipe_hold got %0d want 3", first_rdy);
      end
   endtask

   task automatic test_polarity_b();
      int bad_hs = 0, bad_vs = 0, bad_rd = 0, bad_ms = 0, hs_hi = 0;
      rst_b = 1; ce_b = 1;
      @(negedge clk);
      rst_b = 0;
      for (int k = 0; k < 11200; k++) begin
         int h, v;
         logic de;
         #1;
         h = k % 800;
         v = (k / 800) % 7;
         de = (h < 640) && (v < 4);
         if (if_b.HSync !== ((h >= 656) && (h < 752))) bad_hs++;
         if (if_b.VSync !== (v == 5)) bad_vs++;
         if (if_b.vga_Ready !== de) bad_rd++;
         if (if_b.pos_H !== 11'(h) || if_b.pos_V !== 11'(v) ||
             if_b.pix_Y !== (de ? 11'(v) : 11'd0) ||
             if_b.v_Blank !== (v >= 4) ||
             if_b.frame_Cnt !== 16'(k / 5600)) begin
            if (bad_ms == 0)
               $display("FAIL b_misc k=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                        k, if_b.pos_H, if_b.pos_V, if_b.frame_Cnt,
                        h, v, k / 5600);
            bad_ms++;
         end
         hs_hi += int'(if_b.HSync);
         @(negedge clk);
      end
      #1;
      ce_b = 0;
      checks++;
      if (bad_hs != 0 || hs_hi != 1344) begin
         errors++;
         $display("FAIL b_hsync got %0d bad %0d high want 0 bad 1344 high",
                  bad_hs, hs_hi);
      end
      checks++;
      if (bad_vs != 0) begin
         errors++;
         $display("FAIL b_vsync got %0d bad want 0", bad_vs);
      end
      checks++;
      if (bad_rd != 0) begin
         errors++;
         $display("FAIL b_ready got %0d bad want 0", bad_rd);
      end
      checks++;
      if (bad_ms != 0) begin
         errors++;
         $display("FAIL b_misc_total got %0d bad want 0", bad_ms);
      end
      checks++;
      if (if_b.frame_Cnt !== 16'd2) begin
         errors++;
         $display("FAIL b_fcnt got %0d want 2", if_b.frame_Cnt);
      end
   endtask

   task automatic test_frame_d();
      int bad = 0, vs_low = 0, first_vs = -1, rdy = 0;
      rst_d = 1; ce_d = 1;
      @(negedge clk);
      rst_d = 0;
      for (int k = 0; k < 12600; k++) begin
         int h, v;
         #1;
         h = k % 12;
         v = (k / 12) % 525;
         if (if_d.pos_H !== 11'(h) || if_d.pos_V !== 11'(v) ||
             if_d.frame_Cnt !== 16'(k / 6300)) begin
            if (bad == 0)
               $display("FAIL d_pos k=%0d got %0d,%0d want %0d,%0d",
                        k, if_d.pos_H, if_d.pos_V, h, v);
            bad++;
         end
         if (if_d.VSync == 1'b0) begin
            vs_low++;
            if (first_vs < 0) first_vs = k;
         end
         rdy += int'(if_d.vga_Ready);
         @(negedge clk);
      end
      #1;
      ce_d = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL d_counters got %0d bad want 0", bad);
      end
      checks++;
      if (vs_low != 48 || first_vs != 5880) begin
         errors++;
         $display("FAIL d_vsync got %0d,%0d want 48,5880",
                  vs_low, first_vs);
      end
      checks++;
      if (rdy != 7680) begin
         errors++;
         $display("FAIL d_ready got %0d want 7680", rdy);
      end
      checks++;
      if (if_d.frame_Cnt !== 16'd2) begin
         errors++;
         $display("FAIL d_fcnt got %0d want 2", if_d.frame_Cnt);
      end
   endtask

   task automatic test_small_c();
      int mh = 0, mv = 0, bad = 0, wraps = 0;
      logic [15:0] mf = '0;
      logic hs_h [2];
      logic vs_h [2];
      logic de_h [2];
      hs_h = '{1'b1, 1'b1};
      vs_h = '{1'b1, 1'b1};
      de_h = '{1'b0, 1'b0};
      rst_c = 1; ce_c = 1;
      @(negedge clk);
      rst_c = 0;
      for (int k = 0; k < 400; k++) begin
         logic de, hs, vs, ls, fs;
         ce_c = ($urandom_range(0, 3) != 0);
         #1;
         de = (mh < 8) && (mv < 4);
         hs = (mh >= 9) && (mh < 11);
         vs = (mv == 5);
         ls = ce_c && (mh == 0);
         fs = ls && (mv == 0);
         if (if_c.pos_H !== 4'(mh) || if_c.pos_V !== 4'(mv) ||
             if_c.pix_X !== (de ? 4'(mh) : 4'd0) ||
             if_c.pix_Y !== (de ? 4'(mv) : 4'd0) ||
             if_c.HSync !== hs_h[1] || if_c.VSync !== vs_h[1] ||
             if_c.vga_Ready !== de_h[1] ||
             if_c.line_Start !== ls || if_c.frame_Start !== fs ||
             if_c.v_Blank !== (mv >= 4) || if_c.frame_Cnt !== mf) begin
            if (bad == 0)
               $display("FAIL c_trace k=%0d got h%0d v%0d hs%b vs%b de%b f%0d want h%0d v%0d hs%b vs%b de%b f%0d",
                        k, if_c.pos_H, if_c.pos_V, if_c.HSync,
                        if_c.VSync, if_c.vga_Ready, if_c.frame_Cnt,
                        mh, mv, hs_h[1], vs_h[1], de_h[1], mf);
            bad++;
         end
         if (ce_c) begin
            hs_h[1] = hs_h[0]; hs_h[0] = ~hs;
            vs_h[1] = vs_h[0]; vs_h[0] = ~vs;
            de_h[1] = de_h[0]; de_h[0] = de;
            if (mh == 11) begin
               mh = 0;
               if (mv == 6) begin
                  mv = 0;
                  mf = mf + 16'd1;
                  wraps++;
               end else begin
                  mv = mv + 1;
               end
            end else begin
               mh = mh + 1;
            end
         end
         @(negedge clk);
      end
      ce_c = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL c_golden got %0d bad want 0", bad);
      end
      #1;
      checks++;
      if (if_c.frame_Cnt !== mf || wraps < 2) begin
         errors++;
         $display("FAIL c_wraps got %0d want %0d (>=2)",
                  if_c.frame_Cnt, mf);
      end
   endtask

   task automatic test_reset_mid_c();
      ce_c = 1;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (if_c.pos_H == 4'd5 && if_c.pos_V == 4'd3 &&
             if_c.frame_Cnt != 16'd0) break;
         @(negedge clk);
      end
      checks++;
      if (if_c.pos_H !== 4'd5 || if_c.pos_V !== 4'd3 ||
          if_c.vga_Ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reach got %0d,%0d,%b want 5,3,1",
                  if_c.pos_H, if_c.pos_V, if_c.vga_Ready);
      end
      rst_c = 1;
      @(negedge clk);
      rst_c = 0;
      ce_c = 0;
      #1;
      checks++;
      if (if_c.pos_H !== 4'd0 || if_c.pos_V !== 4'd0 ||
          if_c.vga_Ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_pos got %0d,%0d,%b want 0,0,0",
                  if_c.pos_H, if_c.pos_V, if_c.vga_Ready);
      end
      checks++;
      if (if_c.HSync !== 1'b1 || if_c.VSync !== 1'b1 ||
          if_c.frame_Cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_rst_sync got %b%b f%0d want 11 f0",
                  if_c.HSync, if_c.VSync, if_c.frame_Cnt);
      end
      checks++;
      if (if_c.frame_Start !== 1'b0) begin
         errors++;
         $display("FAIL mid_fs_stalled got %b want 0", if_c.frame_Start);
      end
      ce_c = 1;
      #1;
      checks++;
      if (if_c.frame_Start !== 1'b1) begin
         errors++;
         $display("FAIL mid_fs_enabled got %b want 1", if_c.frame_Start);
      end
      @(negedge clk);
      ce_c = 0;
      #1;
      checks++;
      if (if_c.pos_H !== 4'd1) begin
         errors++;
         $display("FAIL mid_advance got %0d want 1", if_c.pos_H);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
      ce_a = 0; ce_b = 0; ce_c = 0; ce_d = 0;
      @(negedge clk);
      test_reset();
      test_line_a();
      test_ce_toggle_a();
      test_polarity_b();
      test_frame_d();
      test_small_c();
      test_reset_mid_c();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
